// File: rtl/bfp16_accum.sv
// BFP16 sequential accumulator: sums a counted stream of BFP16 words using
// an external combinational adder, one element every two cycles.
module bfp16_accum #(
    parameter int SIZE_DATA  = 32,
    parameter int SIZE_COUNT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [SIZE_COUNT-1:0] i_length,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE_DATA-1:0]  i_data,
    output logic [SIZE_DATA-1:0]  o_add_a,
    output logic [SIZE_DATA-1:0]  o_add_b,
    input  logic [SIZE_DATA-1:0]  i_add_sum,
    output logic [SIZE_DATA-1:0]  o_sum,
    output logic [SIZE_COUNT-1:0] o_count,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [SIZE_DATA-1:0]  acc_q, acc_d;
    logic [SIZE_DATA-1:0]  op_q, op_d;
    logic [SIZE_COUNT-1:0] count_q, count_d;
    logic [SIZE_COUNT-1:0] len_q, len_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        count_d = count_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    acc_d   = '0;
                    count_d = '0;
                    len_d   = i_length;
                    state_d = (i_length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (i_valid) begin
                    op_d    = i_data;
                    count_d = count_q + SIZE_COUNT'(1);
                    state_d = ADD;
                end
            end
            ADD: begin
                // The adder forces a hidden 1 on operand a, so a zero
                // accumulator must be replaced rather than added to.
                acc_d   = (acc_q == '0) ? op_q : i_add_sum;
                state_d = (count_q == len_q) ? DONE : RUN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign o_ready = (state_q == RUN);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);
    assign o_add_a = acc_q;
    assign o_add_b = op_q;
    assign o_sum   = acc_q;
    assign o_count = count_q;

endmodule
